id_ex_latch: RTL
================

Name: id_ex_latch

Overview:
ID/EX pipeline register of the 5-stage MIPS pipeline. It sits between the decode stage (control unit, register file, sign-extender) and the execute stage. It registers the WB/M/EX control groups, operands, immediate and register addresses. Its outputs drive the ALU, the ALU-control decoder (funct = imm[5:0], aluop) and the EX/MEM latch. It also detects load-use hazards, inserts one bubble, and supports hold and flush.

Parameters:
DATA_W, 32, width of operands, next-PC and sign-extended immediate
REG_AW, 5, register-address width
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  decode stage holds a real instruction
hold_in  in  1  downstream freeze; latch keeps its contents
flush_in  in  1  squash (taken branch); latch loads a bubble
ctlwb_in  in  2  {regwrite, memtoreg}
ctlm_in  in  3  {branch, memread, memwrite}
ctlex_in  in  4  {regdst, aluop[1:0], alusrc}
npc_in  in  DATA_W  PC+4 of decode instruction
rd1_in  in  DATA_W  register-file read data 1
rd2_in  in  DATA_W  register-file read data 2
imm_in  in  DATA_W  sign-extended immediate
rs_in  in  REG_AW  instr[25:21]
rt_in  in  REG_AW  instr[20:16]
rd_in  in  REG_AW  instr[15:11]
ctlwb_out  out  2  registered WB controls
ctlm_out  out  3  registered M controls
regdst_out  out  1  registered regdst
aluop_out  out  2  registered aluop
alusrc_out  out  1  registered alusrc
npc_out  out  DATA_W  registered next-PC
rd1_out  out  DATA_W  registered read data 1
rd2_out  out  DATA_W  registered read data 2
imm_out  out  DATA_W  registered immediate
funct_out  out  6  imm_out[5:0], combinational
rt_out  out  REG_AW  registered rt
rd_out  out  REG_AW  registered rd
valid_out  out  1  EX stage holds a real instruction
stall_out  out  1  freeze PC and IF/ID (combinational)
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0. aluop_out=2'b00, valid_out=0, bubble_cnt=0. Takes effect immediately, including mid-stall.
- Hazard (combinational): hazard = valid_out & ctlm_out[1] & valid_in & (rt_out!=0) & (rt_out==rs_in | rt_out==rt_in).
- stall_out = hazard | hold_in.
- Priority at each rising edge, highest first:
  1. flush_in: bubble.
  2. hold_in: retain all registers, including valid_out.
  3. hazard: bubble.
  4. otherwise: load all inputs; valid_out <= valid_in.
- Bubble: ctlwb/ctlm/ctlex fields <= 0 and valid_out <= 0. Data and address fields load their inputs (don't-care). aluop=00 gives a harmless add.
- Control is gated when valid_in=0: if valid_in=0 on a load, all control fields load as 0.
- aluop=2'b11 (invalid opcode) passes through unchanged so the ALU-control decoder can flag it.
- Latency: exactly 1 cycle, input to output.
- A load-use hazard self-clears after one bubble, because memread_out is 0 the following cycle. Back-to-back loads each stall once.
- flush_in together with hazard: flush wins. stall_out still asserts for that cycle.
- flush_in together with hold_in: flush wins.
- bubble_cnt increments on every edge that writes a bubble caused by hazard or flush, but not by valid_in=0. It saturates at all-ones and never wraps.

Decomposition:
- Shared package mips_pkg holds the control-bit index constants (REGWRITE, MEMTOREG, BRANCH, MEMREAD, MEMWRITE, REGDST, ALUSRC, aluop slice) and the aluop encodings (lwsw 00, itype 01, rtype 10, unknown 11).
- One sub-module is natural: hazard_unit, a combinational load-use compare producing hazard.
- Counter and register stay in id_ex_latch.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, valid_out=0, bubble_cnt=0.
- Pass-through: R-type add, ctlex=4'b1100, imm[5:0]=6'b100000, rd1=5, rd2=7 -> next cycle aluop_out=10, funct_out=100000, rd1_out=5, rd2_out=7, valid_out=1.
- Load-use: lw $8 then add $9,$8,$3 -> stall_out=1 for one cycle, EX gets bubble (ctlwb_out=0, ctlm_out=0, valid_out=0), add enters next cycle, bubble_cnt=1.
- No false hazard: lw $0 then use $0 -> no stall; lw $8 then use $10 -> no stall.
- Priority: flush_in=1 with hazard and hold_in both asserted -> bubble written, bubble_cnt+1. Then hold_in alone for 3 cycles -> outputs frozen, stall_out=1.
- Saturation: preset CNT_W=4, force 20 flushes -> bubble_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline control-bit indices and aluop encodings
package mips_pkg;

    // ctlwb = {regwrite, memtoreg}
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;

    // ctlm = {branch, memread, memwrite}
    localparam int BRANCH   = 2;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;

    // ctlex = {regdst, aluop[1:0], alusrc}
    localparam int REGDST   = 3;
    localparam int ALUOP_HI = 2;
    localparam int ALUOP_LO = 1;
    localparam int ALUSRC   = 0;

    localparam int CTLWB_W = 2;
    localparam int CTLM_W  = 3;
    localparam int CTLEX_W = 4;

    typedef enum logic [1:0] {
        ALUOP_LWSW    = 2'b00,
        ALUOP_ITYPE   = 2'b01,
        ALUOP_RTYPE   = 2'b10,
        ALUOP_UNKNOWN = 2'b11
    } aluop_e;

endpackage

// File: rtl/id_ex_latch_if.sv
// rtl/id_ex_latch_if.sv - decode-side inputs and execute-side outputs of the ID/EX latch
interface id_ex_latch_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              valid_in;
    logic              hold_in;
    logic              flush_in;
    logic [1:0]        ctlwb_in;
    logic [2:0]        ctlm_in;
    logic [3:0]        ctlex_in;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic [DATA_W-1:0] imm_in;
    logic [REG_AW-1:0] rs_in;
    logic [REG_AW-1:0] rt_in;
    logic [REG_AW-1:0] rd_in;

    logic [1:0]        ctlwb_out;
    logic [2:0]        ctlm_out;
    logic              regdst_out;
    logic [1:0]        aluop_out;
    logic              alusrc_out;
    logic [DATA_W-1:0] npc_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] imm_out;
    logic [5:0]        funct_out;
    logic [REG_AW-1:0] rt_out;
    logic [REG_AW-1:0] rd_out;
    logic              valid_out;
    logic              stall_out;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output valid_in, hold_in, flush_in, ctlwb_in, ctlm_in, ctlex_in,
               npc_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in,
        input  ctlwb_out, ctlm_out, regdst_out, aluop_out, alusrc_out,
               npc_out, rd1_out, rd2_out, imm_out, funct_out, rt_out, rd_out,
               valid_out, stall_out, bubble_cnt
    );

    modport slave (
        input  valid_in, hold_in, flush_in, ctlwb_in, ctlm_in, ctlex_in,
               npc_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in,
        output ctlwb_out, ctlm_out, regdst_out, aluop_out, alusrc_out,
               npc_out, rd1_out, rd2_out, imm_out, funct_out, rt_out, rd_out,
               valid_out, stall_out, bubble_cnt
    );
endinterface

// File: rtl/id_ex_latch_hazard.sv
// rtl/id_ex_latch_hazard.sv - load-use compare between the load in EX and the instruction in ID
module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              valid_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              valid_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    output logic              hazard
);
    // $0 is never a real destination, so a load into it cannot create a dependency
    assign hazard = valid_ex & memread_ex & valid_id & (rt_ex != '0) &
                    ((rt_ex == rs_id) | (rt_ex == rt_id));
endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline register with load-use bubble, hold and flush
module id_ex_latch
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_latch_if.slave bus
);
    logic [CTLWB_W-1:0] ctlwb_q;
    logic [CTLM_W-1:0]  ctlm_q;
    logic [CTLEX_W-1:0] ctlex_q;
    logic [DATA_W-1:0]  npc_q, rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0]  rt_q, rd_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic hazard;
    logic bubble;
    logic load;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .valid_ex   (valid_q),
        .memread_ex (ctlm_q[MEMREAD]),
        .rt_ex      (rt_q),
        .valid_id   (bus.valid_in),
        .rs_id      (bus.rs_in),
        .rt_id      (bus.rt_in),
        .hazard     (hazard)
    );

    // flush overrides hold; hold overrides a hazard bubble
    assign bubble = bus.flush_in | (~bus.hold_in & hazard);
    assign load   = bus.flush_in | ~bus.hold_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctlwb_q <= '0;
            ctlm_q  <= '0;
            ctlex_q <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (load) begin
                npc_q <= bus.npc_in;
                rd1_q <= bus.rd1_in;
                rd2_q <= bus.rd2_in;
                imm_q <= bus.imm_in;
                rt_q  <= bus.rt_in;
                rd_q  <= bus.rd_in;
                if (bubble || !bus.valid_in) begin
                    ctlwb_q <= '0;
                    ctlm_q  <= '0;
                    ctlex_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    ctlwb_q <= bus.ctlwb_in;
                    ctlm_q  <= bus.ctlm_in;
                    ctlex_q <= bus.ctlex_in;
                    valid_q <= 1'b1;
                end
            end
            if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ctlwb_out  = ctlwb_q;
    assign bus.ctlm_out   = ctlm_q;
    assign bus.regdst_out = ctlex_q[REGDST];
    assign bus.aluop_out  = ctlex_q[ALUOP_HI:ALUOP_LO];
    assign bus.alusrc_out = ctlex_q[ALUSRC];
    assign bus.npc_out    = npc_q;
    assign bus.rd1_out    = rd1_q;
    assign bus.rd2_out    = rd2_q;
    assign bus.imm_out    = imm_q;
    assign bus.funct_out  = imm_q[5:0];
    assign bus.rt_out     = rt_q;
    assign bus.rd_out     = rd_q;
    assign bus.valid_out  = valid_q;
    assign bus.stall_out  = hazard | bus.hold_in;
    assign bus.bubble_cnt = cnt_q;
endmodule
